// File: rtl/mdio_controller.sv
// MDIO management master. Each bit period is two CLK cycles: MDC low, then MDC high.
// Define MDIO_PREAMBLE_EN to send 32 preamble ones before every frame.
`timescale 1ns/1ps
module mdio_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        MDIO_DONE,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE       = 3'd0;
`ifdef MDIO_PREAMBLE_EN
  localparam logic [2:0] S_PREAMBLE   = 3'd1;
`endif
  localparam logic [2:0] S_SEND       = 3'd2;
  localparam logic [2:0] S_TURNAROUND = 3'd3;
  localparam logic [2:0] S_RECEIVE    = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  // Index of the final bit period in each counted state.
  localparam logic [4:0] SEND_LAST_RD = 5'd13;
  localparam logic [4:0] SEND_LAST_WR = 5'd31;
  localparam logic [4:0] TA_LAST      = 5'd1;
  localparam logic [4:0] RX_LAST      = 5'd15;

`ifdef MDIO_PREAMBLE_EN
  localparam logic [2:0] S_FIRST      = S_PREAMBLE;
  localparam logic [4:0] PRE_LAST     = 5'd31;
`else
  localparam logic [2:0] S_FIRST      = S_SEND;
`endif

  logic [2:0]  r_state;
  logic        r_phase;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_tx;
  logic [15:0] r_rx;
  logic [15:0] r_rd_data;
  logic        r_is_read;
`ifdef MDIO_PREAMBLE_EN
  logic [4:0]  r_pre_cnt;
`endif

  logic [2:0]  w_next_state;
  logic        w_entry;
  logic        w_preamble;
  logic        w_frame_bit;
  logic        w_in_bit;
  logic [4:0]  w_send_last;
  logic [15:0] w_rx_next;

`ifdef MDIO_PREAMBLE_EN
  assign w_preamble = (r_state == S_PREAMBLE);
`else
  assign w_preamble = 1'b0;
`endif

  assign w_frame_bit = (r_state == S_SEND) || (r_state == S_TURNAROUND) ||
                       (r_state == S_RECEIVE);
  assign w_in_bit    = w_frame_bit || w_preamble;
  assign w_send_last = r_is_read ? SEND_LAST_RD : SEND_LAST_WR;
  assign w_rx_next   = {r_rx[14:0], MDIO_IN};
  assign w_entry     = (w_next_state != r_state);

  // NOTE: default assignment first so no path through the case leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (MDIO_START) w_next_state = S_FIRST;
`ifdef MDIO_PREAMBLE_EN
      S_PREAMBLE:   if (r_phase && r_pre_cnt == PRE_LAST) w_next_state = S_SEND;
`endif
      S_SEND:       if (r_phase && r_bit_cnt == w_send_last)
                      w_next_state = r_is_read ? S_TURNAROUND : S_DONE;
      S_TURNAROUND: if (r_phase && r_bit_cnt == TA_LAST) w_next_state = S_RECEIVE;
      S_RECEIVE:    if (r_phase && r_bit_cnt == RX_LAST) w_next_state = S_DONE;
      S_DONE:       w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every register uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_entry || !w_in_bit) r_phase <= 1'b0;
      else                      r_phase <= ~r_phase;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bit_cnt <= 5'd0;
    end else if (w_entry) begin
      r_bit_cnt <= 5'd0;
    end else if (w_frame_bit && r_phase) begin
      r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

`ifdef MDIO_PREAMBLE_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pre_cnt <= 5'd0;
    end else if (w_entry) begin
      r_pre_cnt <= 5'd0;
    end else if (w_preamble && r_phase) begin
      r_pre_cnt <= r_pre_cnt + 5'd1;
    end
  end
`endif

  // Frame is captured once at acceptance; later T_DATA changes are invisible.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx      <= 32'h0;
      r_is_read <= 1'b0;
    end else if (r_state == S_IDLE && MDIO_START) begin
      r_tx      <= T_DATA;
      r_is_read <= (T_DATA[29:28] == 2'b10);
    end else if (r_state == S_SEND && r_phase) begin
      r_tx      <= {r_tx[30:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx      <= 16'h0;
      r_rd_data <= 16'h0;
    end else begin
      if (r_state == S_IDLE && MDIO_START) r_rx <= 16'h0;
      else if (r_state == S_RECEIVE && r_phase) r_rx <= w_rx_next;
      // The final bit is sampled on the same edge that enters DONE.
      if (r_state == S_RECEIVE && w_next_state == S_DONE) r_rd_data <= w_rx_next;
    end
  end

  assign MDC       = w_in_bit && r_phase;
  assign MDIO_OE   = (r_state == S_SEND) || w_preamble;
  assign MDIO_OUT  = ((r_state == S_SEND) && r_tx[31]) || w_preamble;
  assign MDIO_DONE = (r_state == S_DONE);
  assign BUSY      = (r_state != S_IDLE);
  assign RD_DATA   = r_rd_data;

endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller: vector table, corner sequences and random frames
// compared cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE_BITS = 32;
`else
  localparam int PRE_BITS = 0;
`endif
  localparam int LAT = 2 * (PRE_BITS + 32) + 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, BUSY;
  logic [15:0] RD_DATA;

  mdio_controller dut (
    .CLK(CLK), .RESET(RESET), .MDIO_START(MDIO_START), .T_DATA(T_DATA),
    .MDIO_IN(MDIO_IN), .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .RD_DATA(RD_DATA), .MDIO_DONE(MDIO_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] rd;
    logic        mdc;
    logic        out;
    logic        oe;
    logic        done;
    logic        busy;
  } cyc_t;

  typedef struct {
    logic [31:0] td;
    logic [15:0] rx;
    logic [15:0] exp_rd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [15:0] model_rd = 16'h0;
  time         last_done_t = 0;

  always @(negedge CLK) if (MDIO_DONE === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic cyc_t mk(input logic mdc, input logic out, input logic oe);
    cyc_t e;
    e.rd = model_rd; e.mdc = mdc; e.out = out; e.oe = oe; e.done = 1'b0; e.busy = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] actual();
    return {11'b0, RD_DATA, MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, BUSY};
  endfunction

  // Entered part-way through an IDLE cycle; returns part-way through the IDLE cycle after DONE.
  task automatic run_frame(input logic [31:0] td, input logic [15:0] rx, input int stray,
                           input bit hold, input logic [31:0] next_td);
    cyc_t q[$];
    cyc_t e;
    logic is_rd;
    int   n_send, rx_off, done_seen, dc0;
    is_rd  = (td[29:28] == 2'b10);
    n_send = is_rd ? 14 : 32;
    rx_off = 2 * PRE_BITS + 2 * 14 + 4;
    for (int i = 0; i < PRE_BITS; i++)
      for (int h = 0; h < 2; h++) q.push_back(mk(logic'(h), 1'b1, 1'b1));
    for (int i = 0; i < n_send; i++)
      for (int h = 0; h < 2; h++) q.push_back(mk(logic'(h), td[31-i], 1'b1));
    if (is_rd)
      for (int i = 0; i < 18; i++)
        for (int h = 0; h < 2; h++) q.push_back(mk(logic'(h), 1'b0, 1'b0));
    e = mk(1'b0, 1'b0, 1'b0);
    e.done = 1'b1;
    if (is_rd) e.rd = rx;
    q.push_back(e);

    dc0 = done_cnt;
    done_seen = 0;
    MDIO_START = 1'b1;
    T_DATA = td;
    @(posedge CLK); #1;
    T_DATA = hold ? next_td : $urandom;
    for (int c = 1; c <= q.size(); c++) begin
      if (is_rd && c > rx_off && c <= rx_off + 32) MDIO_IN = rx[15 - (c - 1 - rx_off) / 2];
      else MDIO_IN = 1'($urandom);
      MDIO_START = hold || (c == stray);
      if (c == stray) T_DATA = $urandom;
      @(negedge CLK);
      check($sformatf("cyc%0d td=%h", c, td), actual(), {11'b0, q[c-1]});
      if (MDIO_DONE === 1'b1 && done_seen == 0) begin
        done_seen = c;
        last_done_t = $time;
      end
      @(posedge CLK); #1;
    end
    MDIO_START = hold;
    model_rd = e.rd;
    #3;
    check("idle_after_done", actual(), {11'b0, model_rd, 5'b0});
    check("latency", done_seen, LAT);
    check("done_pulses", done_cnt - dc0, 1);
  endtask

  vec_t        vecs[8];
  logic [31:0] td;
  logic [15:0] rx;
  int          stray;
  time         t1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h508AABCD, 16'h0000, 16'h0000};
    vecs[1] = '{32'h60880000, 16'hAAAB, 16'hAAAB};
    vecs[2] = '{32'h508AABCD, 16'h5555, 16'hAAAB};
    vecs[3] = '{32'h40000000, 16'h1111, 16'hAAAB};
    vecs[4] = '{32'h7FFFFFFF, 16'h2222, 16'hAAAB};
    vecs[5] = '{32'h6FFC0000, 16'h1234, 16'h1234};
    vecs[6] = '{32'h20000000, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{32'h5FFFFFFF, 16'h0F0F, 16'hFFFF};

    RESET = 1'b1; MDIO_START = 1'b0; T_DATA = 32'h0; MDIO_IN = 1'b0;
    #3;
    check("reset_state", actual(), 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].td, vecs[i].rx, 0, 1'b0, 32'h0);
      check($sformatf("tbl%0d_rd_data", i), {16'h0, RD_DATA}, {16'h0, vecs[i].exp_rd});
    end

    // Second START during the write must be ignored.
    run_frame(32'h508AABCD, 16'h0, 10, 1'b0, 32'h0);

    // START held high: second write begins right after DONE.
    run_frame(32'h508AABCD, 16'h0, 0, 1'b1, 32'h5A5A1234);
    t1 = last_done_t;
    run_frame(32'h5A5A1234, 16'h0, 0, 1'b0, 32'h0);
    check("b2b_done_spacing", 32'((last_done_t - t1) / 10), 32'd66);

    // Reset in the middle of a read.
    MDIO_START = 1'b1; T_DATA = 32'h60880000;
    @(posedge CLK); #1;
    MDIO_START = 1'b0;
    repeat (39) @(posedge CLK);
    #1; #2;
    RESET = 1'b1;
    #1;
    check("reset_mid_read_now", actual(), 32'h0);
    @(posedge CLK); #1;
    check("reset_mid_read_held", actual(), 32'h0);
    RESET = 1'b0;
    model_rd = 16'h0;
    #2;
    run_frame(32'h60880000, 16'hAAAB, 0, 1'b0, 32'h0);
    check("post_reset_rd", {16'h0, RD_DATA}, 32'h0000AAAB);

    for (int k = 0; k < 40; k++) begin
      td = $urandom;
      if ($urandom_range(0, 1) == 1) td[29:28] = 2'b10;
      rx = 16'($urandom);
      stray = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, LAT));
      run_frame(td, rx, stray, 1'b0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock; all registers update on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port MDIO_START, input, 1 bit: transaction request, sampled only in IDLE.
REQ-005 The block SHALL have port T_DATA, input, 32 bits: frame [31:30]=ST, [29:28]=OP, [27:23]=PHYAD, [22:18]=REGAD, [17:16]=TA, [15:0]=write data.
REQ-006 The block SHALL have port MDIO_IN, input, 1 bit: serial data returned by the peripheral.
REQ-007 The block SHALL have port MDC, output, 1 bit: management clock.
REQ-008 The block SHALL have port MDIO_OUT, output, 1 bit: serial data toward the peripheral.
REQ-009 The block SHALL have port MDIO_OE, output, 1 bit: high while the controller drives MDIO_OUT.
REQ-010 The block SHALL have port RD_DATA, output, 16 bits: data captured by the last completed read.
REQ-011 The block SHALL have port MDIO_DONE, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high from the cycle after MDIO_START is accepted until MDIO_DONE, inclusive.

Function
REQ-013 The FSM SHALL have the states IDLE, PREAMBLE, SEND, TURNAROUND, RECEIVE and DONE.
REQ-014 MDIO_START=1 in IDLE SHALL latch T_DATA and move to PREAMBLE when MDIO_PREAMBLE_EN is defined, otherwise to SEND.
REQ-015 MDIO_START SHALL be ignored in every state other than IDLE, and T_DATA changes after acceptance SHALL have no effect.
REQ-016 Each bit period SHALL be 2 CLK cycles: phase L with MDC=0, where the new MDIO_OUT bit is presented, followed by phase H with MDC=1.
REQ-017 MDC SHALL be 0 in IDLE and DONE.
REQ-018 Bits SHALL be sent MSB first (T_DATA[31] first).
REQ-019 When OP==2'b10 (read), SEND SHALL drive bits 31..18 (14 bits) with MDIO_OE=1.
REQ-020 In a read, TURNAROUND SHALL last 2 bit periods with MDIO_OE=0 and MDIO_OUT=0.
REQ-021 In a read, RECEIVE SHALL last 16 bit periods, sampling MDIO_IN at the CLK edge that ends each H phase, MSB first, into a shift register.
REQ-022 For any OP value other than 2'b10 (write framing, including 00 and 11), SEND SHALL drive all 32 bits with MDIO_OE=1, then go to DONE.
REQ-023 DONE SHALL last exactly 1 cycle, with MDIO_DONE=1, MDIO_OE=0 and MDIO_OUT=0, and then return to IDLE.
REQ-024 A new MDIO_START SHALL be accepted only in the cycle after DONE or later.
REQ-025 RD_DATA SHALL load the shift register on entry to DONE after a read only.
REQ-026 RD_DATA SHALL hold its value across write transactions.
REQ-027 Latency without preamble: with START sampled at edge 0, bit periods SHALL occupy cycles 1..64 and MDIO_DONE SHALL be high in cycle 65, for both read and write.
REQ-028 Bit and period counters SHALL be sized exactly, SHALL NOT wrap, and SHALL clear on every state entry.

Reset
REQ-029 RESET=1 SHALL, at any time including mid-transaction, immediately force state=IDLE, MDC=0, MDIO_OUT=0, MDIO_OE=0, MDIO_DONE=0, BUSY=0, RD_DATA=16'h0000 and clear all counters and the shift register.
REQ-030 After RESET is released, the first MDIO_START SHALL be honoured on the next rising CLK edge.

Configuration
REQ-031 When macro MDIO_PREAMBLE_EN is defined, PREAMBLE SHALL send 32 bit periods of MDIO_OUT=1 with MDIO_OE=1 before SEND, making the latency to MDIO_DONE 129 cycles.
REQ-032 When MDIO_PREAMBLE_EN is not defined, the PREAMBLE state and its counter SHALL be omitted and the REQ-027 latency SHALL apply.

Verification
REQ-033 Write: T_DATA=32'h508AABCD, with a START pulse -> MDIO_OUT serialises 0101_00001_00010_10_1010101111001101 on MDC rising edges, MDIO_OE=1 for 64 cycles, MDIO_DONE in cycle 65, RD_DATA unchanged.
REQ-034 Read: T_DATA=32'h60880000, with the peripheral driving 16'hAAAB during RECEIVE -> MDIO_OE drops after 14 bits, RD_DATA=16'hAAAB with MDIO_DONE in cycle 65.
REQ-035 Busy rejection: a second START at cycle 10 of a write -> ignored, exactly one MDIO_DONE, frame intact.
REQ-036 Reset mid-read: RESET asserted at cycle 40 -> all outputs at reset values within the same cycle, RD_DATA=0, and the next START runs a clean frame.
REQ-037 Back-to-back: START held high -> a second write starts the cycle after DONE, with two MDIO_DONE pulses 66 cycles apart.
REQ-038 With MDIO_PREAMBLE_EN defined: a write -> 64 cycles of MDIO_OUT=1 precede ST=01, and MDIO_DONE occurs in cycle 129.
